// File: rtl/lfsr_rand_arbiter_if.sv
// Request/grant bundle between NUM_REQ requesters and the shared-resource arbiter.
// The owner ends its transaction with release_gnt, because "release" is a reserved word.
interface lfsr_rand_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: req[i] is a level request, sampled only while idle. A grant
    // (one-hot gnt, binary gnt_idx, busy high) is held unchanged until
    // release_gnt is seen high on a clock edge while busy. release_gnt is
    // ignored while idle. req may drop during a grant without affecting it.
    logic [NUM_REQ-1:0] req;
    logic               release_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               busy;

    modport master (output req, release_gnt, input gnt, gnt_idx, busy);
    modport slave  (input req, release_gnt, output gnt, gnt_idx, busy);
endinterface

// File: rtl/lfsr_rand_arbiter.sv
// Multi-cycle grant arbiter: an 8-bit XNOR LFSR picks the scan start point, and
// per-requester starvation counters force a grant after STARVE_LIMIT lost decisions.
module lfsr_rand_arbiter #(
    parameter int         NUM_REQ      = 4,
    parameter int         STARVE_LIMIT = 7,
    parameter logic [7:0] SEED         = 8'h01
) (
    input  logic                  clock,
    input  logic                  reset,
    lfsr_rand_arbiter_if.slave    bus,
    output logic [7:0]            lfsr_state,
    output logic                  fsm_state,
    output logic [NUM_REQ*4-1:0]  starve_cnt
);
    localparam int         IDX_W     = $clog2(NUM_REQ);
    // All-ones is the XNOR lock-up state, so it is never loaded.
    localparam logic [7:0] SEED_SAFE = (SEED == 8'hFF) ? 8'h00 : SEED;
    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state, state_next;
    logic [7:0]         lfsr, lfsr_next;
    logic [3:0]         cnt [NUM_REQ];
    logic [3:0]         cnt_next [NUM_REQ];
    logic [NUM_REQ-1:0] gnt_q, gnt_next;
    logic [IDX_W-1:0]   idx_q, idx_next;
    logic [IDX_W-1:0]   start, cand, rr_idx, starve_idx, winner;
    logic               starve_hit;

    assign start = lfsr[IDX_W-1:0];

    // Descending scans so the lowest index / smallest offset is written last and wins.
    always_comb begin : pick_winner
        starve_hit = 1'b0;
        starve_idx = '0;
        rr_idx     = '0;
        cand       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i] && (cnt[i] >= LIMIT)) begin
                starve_hit = 1'b1;
                starve_idx = IDX_W'(i);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = start + IDX_W'(k);
            if (bus.req[cand]) begin
                rr_idx = cand;
            end
        end
        winner = starve_hit ? starve_idx : rr_idx;
    end

    always_comb begin : next_state_logic
        state_next = state;
        lfsr_next  = lfsr;
        gnt_next   = gnt_q;
        idx_next   = idx_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_next[i] = cnt[i];
        end
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_next       = BUSY;
                    lfsr_next        = {lfsr[6:0], ~(lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3])};
                    gnt_next         = '0;
                    gnt_next[winner] = 1'b1;
                    idx_next         = winner;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (IDX_W'(i) == winner) begin
                            cnt_next[i] = 4'd0;
                        end else if (bus.req[i]) begin
                            cnt_next[i] = (cnt[i] == 4'd15) ? cnt[i] : cnt[i] + 4'd1;
                        end else begin
                            cnt_next[i] = 4'd0;
                        end
                    end
                end
            end
            BUSY: begin
                if (bus.release_gnt) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            lfsr  <= SEED_SAFE;
            gnt_q <= '0;
            idx_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= 4'd0;
            end
        end else begin
            state <= state_next;
            lfsr  <= lfsr_next;
            gnt_q <= gnt_next;
            idx_q <= idx_next;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.busy    = (state == BUSY);
    assign lfsr_state  = lfsr;
    assign fsm_state   = (state == BUSY);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign starve_cnt[g*4 +: 4] = cnt[g];
    end
endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
- Grants one shared resource (e.g., a cache refill port or free-list write port) to one of NUM_REQ requesters.
- Each grant is held for a multi-cycle transaction until the owner releases it.
- Priority start point is randomized by an internal XNOR Fibonacci LFSR, so no fixed requester is favoured.
- Per-requester starvation counters force a grant once a requester has lost STARVE_LIMIT consecutive decisions.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..16.
- IDX_W, $clog2(NUM_REQ), grant index width; derived, not overridden.
- STARVE_LIMIT, 7, losses after which a requester is forced; 1..15.
- SEED, 8'h01, LFSR reset value; 8'hFF is illegal (XNOR lock-up) and is replaced by 8'h00 at reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester.
- release  in  1  owner ends transaction; honoured only in BUSY.
- gnt  out  NUM_REQ  registered one-hot grant; all zero when idle.
- gnt_idx  out  IDX_W  binary index of the granted requester; 0 when idle.
- busy  out  1  high while in BUSY.
- lfsr_state  out  8  current LFSR value, for debug and verification.

Behaviour:
- Reset (synchronous): state=IDLE, gnt=0, gnt_idx=0, busy=0, all starvation counters=0, lfsr=SEED (8'h00 if SEED==8'hFF). Reset overrides everything, including mid-BUSY; the grant drops on the next edge.
- LFSR, 8-bit:
  - fb = ~(l[7]^l[5]^l[4]^l[3]); next = {l[6:0], fb}.
  - Advances only on cycles where a grant decision is made.
  - Example sequence from 8'h01: 01, 03, 07, 0F, 1E.
- FSM: two states, IDLE and BUSY.
- IDLE:
  - If req==0: stay IDLE, no LFSR step, counters unchanged.
  - Else, decide a winner:
    - If any requester with req set has cnt>=STARVE_LIMIT, the winner is the lowest such index.
    - Otherwise start=lfsr[IDX_W-1:0] and the winner is the first set req scanning start, start+1, ... modulo NUM_REQ (wrap-around).
  - Same edge as the decision: gnt<=onehot(winner), gnt_idx<=winner, busy<=1, state<=BUSY, LFSR steps.
  - Counters at the decision: winner's counter cleared; every other requester with req set increments, saturating at 15; requesters with req clear are cleared.
  - Latency: req sampled in cycle t gives gnt visible in cycle t+1.
- BUSY:
  - gnt and gnt_idx held constant, even if the owner drops req.
  - Counters and LFSR are frozen.
  - On release: gnt<=0, gnt_idx<=0, busy<=0, state<=IDLE.
  - The next decision occurs in that IDLE cycle, so a new grant appears 2 cycles after release. Minimum turnaround is 1 idle cycle.
- release in IDLE is ignored.
- release and req changing in the same cycle: release is acted on; new req values are evaluated in the following IDLE cycle.
- Invariants: gnt is always one-hot or zero; gnt_idx matches gnt; busy==|gnt.

Test Plan:
1. Reset, SEED=8'h01, NUM_REQ=4, req=4'b1111, release pulsed 3 cycles after each grant -> grants to idx 1 (lfsr 01), 3 (03), 3 (07), 3 (0F), 2 (1E); lfsr_state matches the sequence; each grant appears 2 cycles after release.
2. SEED=8'h01, req=4'b0100 only -> gnt=4'b0100 the cycle after req rises; release -> gnt=0 next cycle; req held -> regrant 2 cycles later.
3. Starvation, STARVE_LIMIT=2, req=4'b1011 held, seed chosen so idx0 loses two decisions -> third decision grants idx0 regardless of lfsr; idx0 counter reads 0 afterwards.
4. During BUSY with gnt=4'b0010: drop req[1], raise req[3], pulse release in IDLE-like glitches -> gnt stays 4'b0010 until release; no LFSR step while BUSY.
5. Assert reset while BUSY -> next edge: gnt=0, busy=0, lfsr_state=SEED; the first decision after reset repeats scenario 1's first grant.
6. SEED=8'hFF -> lfsr_state=8'h00 after reset; the sequence proceeds 00, 01, 03, ... with no lock-up.
